// File: rtl/rv_pkg.sv
// Shared RV32I decode constants: major opcodes and the immediate-format encoding.
package rv_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned OPC_W   = 7;
  localparam int unsigned FMT_W   = 3;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;

  typedef enum logic [FMT_W-1:0] {
    FMT_R       = 3'd0,
    FMT_I       = 3'd1,
    FMT_S       = 3'd2,
    FMT_B       = 3'd3,
    FMT_U       = 3'd4,
    FMT_J       = 3'd5,
    FMT_ILLEGAL = 3'd7
  } imm_fmt_e;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder: classifies the opcode and builds the
// sign-extended immediate for every RV32I format.
module imm_decode
  import rv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instruction,
  output logic [XLEN-1:0]    imm,
  output imm_fmt_e           imm_fmt,
  output logic               illegal
);

  logic [INSTR_W-1:0] raw;

  // Each format is first assembled as a 32-bit signed value, then widened.
  always_comb begin
    raw     = '0;
    imm_fmt = FMT_ILLEGAL;
    illegal = 1'b0;
    case (instruction[OPC_W-1:0])
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
        imm_fmt = FMT_I;
        raw     = {{20{instruction[31]}}, instruction[31:20]};
      end
      OPC_STORE: begin
        imm_fmt = FMT_S;
        raw     = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      end
      OPC_BRANCH: begin
        imm_fmt = FMT_B;
        raw     = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};
      end
      OPC_LUI, OPC_AUIPC: begin
        imm_fmt = FMT_U;
        raw     = {instruction[31:12], 12'b0};
      end
      OPC_JAL: begin
        imm_fmt = FMT_J;
        raw     = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                   instruction[20], instruction[30:21], 1'b0};
      end
      OPC_OP: begin
        imm_fmt = FMT_R;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/operand_gen_stage.sv
// Decode-to-execute operand generator: immediate decode, operand A/B muxing,
// and a 2-entry valid/ready skid buffer with flush.
module operand_gen_stage
  import rv_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter bit          SKID_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [XLEN-1:0]    pc,
  input  logic [XLEN-1:0]    rs1_data,
  input  logic [XLEN-1:0]    rs2_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    op_a,
  output logic [XLEN-1:0]    op_b,
  output logic [XLEN-1:0]    imm,
  output logic [XLEN-1:0]    store_data,
  output logic [FMT_W-1:0]   imm_fmt,
  output logic               illegal
);

  typedef struct packed {
    logic [XLEN-1:0]  op_a;
    logic [XLEN-1:0]  op_b;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  store_data;
    logic [FMT_W-1:0] fmt;
    logic             illegal;
  } entry_t;

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_decode #(.XLEN(XLEN)) u_imm_decode (
    .instruction (instruction),
    .imm         (dec_imm),
    .imm_fmt     (dec_fmt),
    .illegal     (dec_illegal)
  );

  entry_t new_entry;
  entry_t main_q, main_d, skid_q, skid_d;
  logic   main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic   main_free_c, in_fire_c;

  // Operand muxes; branches keep rs2 on op_b since the target adder takes imm.
  always_comb begin
    new_entry            = '0;
    new_entry.imm        = dec_imm;
    new_entry.fmt        = dec_fmt;
    new_entry.illegal    = dec_illegal;
    new_entry.store_data = rs2_data;
    case (instruction[OPC_W-1:0])
      OPC_AUIPC, OPC_JAL: new_entry.op_a = pc;
      OPC_LUI:            new_entry.op_a = '0;
      default:            new_entry.op_a = rs1_data;
    endcase
    case (dec_fmt)
      FMT_I, FMT_S, FMT_U, FMT_J: new_entry.op_b = dec_imm;
      default:                    new_entry.op_b = rs2_data;
    endcase
  end

  assign main_free_c = !main_valid_q || out_ready;
  assign in_ready    = SKID_EN ? !skid_valid_q : main_free_c;
  assign in_fire_c   = in_valid && in_ready;

  // Skid control: skid only fills while main is stalled, and always refills
  // main first, which keeps the two entries in FIFO order.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free_c) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        if (in_fire_c) main_d = new_entry;
        main_valid_d = in_fire_c;
      end
    end else if (in_fire_c) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid  = main_valid_q;
  assign op_a       = main_q.op_a;
  assign op_b       = main_q.op_b;
  assign imm        = main_q.imm;
  assign store_data = main_q.store_data;
  assign imm_fmt    = main_q.fmt;
  assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_operand_gen_stage.sv
// Directed bench for operand_gen_stage: decode vectors, backpressure ordering,
// throughput, flush and asynchronous reset, with an XLEN=64 instance alongside.
module tb_operand_gen_stage;

  logic        clk = 1'b0;
  logic        rst_n, flush, in_valid, out_ready;
  logic [31:0] instruction, pc, rs1_data, rs2_data;
  logic        in_ready, out_valid, illegal;
  logic [31:0] op_a, op_b, imm, store_data;
  logic [2:0]  imm_fmt;

  logic        in_ready64, out_valid64, illegal64;
  logic [63:0] op_a64, op_b64, imm64, store_data64;
  logic [2:0]  imm_fmt64;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  operand_gen_stage #(.XLEN(32), .SKID_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .out_valid(out_valid), .out_ready(out_ready), .op_a(op_a), .op_b(op_b), .imm(imm),
    .store_data(store_data), .imm_fmt(imm_fmt), .illegal(illegal)
  );

  operand_gen_stage #(.XLEN(64), .SKID_EN(1'b0)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
    .instruction(instruction), .pc({32'b0, pc}), .rs1_data({32'b0, rs1_data}),
    .rs2_data({32'b0, rs2_data}), .out_valid(out_valid64), .out_ready(out_ready),
    .op_a(op_a64), .op_b(op_b64), .imm(imm64), .store_data(store_data64),
    .imm_fmt(imm_fmt64), .illegal(illegal64)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] p);
    in_valid    = 1'b1;
    instruction = ins;
    pc          = p;
  endtask

  function automatic logic [31:0] addi(input logic [11:0] k);
    return {k, 20'h00093};
  endfunction

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instruction = '0; pc = '0; rs1_data = '0; rs2_data = '0;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_imm", 64'(imm), 64'd0);
    chk("rst_op_a", 64'(op_a), 64'd0);
    tick();
    rst_n = 1'b1;

    // addi x1,x0,-1
    rs1_data = 32'h11; rs2_data = 32'h22; out_ready = 1'b1;
    drive(32'hFFF00093, 32'h40);
    chk("addi_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_imm", 64'(imm), 64'hFFFFFFFF);
    chk("addi_op_b", 64'(op_b), 64'hFFFFFFFF);
    chk("addi_fmt", 64'(imm_fmt), 64'd1);
    chk("addi_op_a", 64'(op_a), 64'h11);
    chk("addi_illegal", 64'(illegal), 64'd0);
    chk("addi_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
    chk("addi_fmt64", 64'(imm_fmt64), 64'd1);

    // sw x2,8(x1)
    rs2_data = 32'h55AA;
    drive(32'h0020A423, 32'h44);
    tick();
    chk("sw_imm", 64'(imm), 64'h8);
    chk("sw_fmt", 64'(imm_fmt), 64'd2);
    chk("sw_store_data", 64'(store_data), 64'h55AA);
    chk("sw_op_b", 64'(op_b), 64'h8);

    // beq x0,x0,-4
    drive(32'hFE000EE3, 32'h48);
    tick();
    chk("beq_imm", 64'(imm), 64'hFFFFFFFC);
    chk("beq_fmt", 64'(imm_fmt), 64'd3);
    chk("beq_op_b", 64'(op_b), 64'h55AA);

    // lui x5,0x12345
    drive(32'h123452B7, 32'h4C);
    tick();
    chk("lui_imm", 64'(imm), 64'h12345000);
    chk("lui_op_a", 64'(op_a), 64'h0);
    chk("lui_fmt", 64'(imm_fmt), 64'd4);

    // auipc x0,1 at pc 0x100
    drive(32'h00001017, 32'h100);
    tick();
    chk("auipc_op_a", 64'(op_a), 64'h100);
    chk("auipc_imm", 64'(imm), 64'h1000);
    chk("auipc_op_b", 64'(op_b), 64'h1000);

    // jal x0,8
    drive(32'h0080006F, 32'h200);
    tick();
    chk("jal_imm", 64'(imm), 64'h8);
    chk("jal_fmt", 64'(imm_fmt), 64'd5);
    chk("jal_op_a", 64'(op_a), 64'h200);

    // add x3,x1,x2
    drive(32'h002081B3, 32'h204);
    tick();
    chk("add_fmt", 64'(imm_fmt), 64'd0);
    chk("add_imm", 64'(imm), 64'h0);
    chk("add_op_b", 64'(op_b), 64'h55AA);
    chk("add_op_a", 64'(op_a), 64'h11);

    // illegal opcode 0x7F
    drive(32'h0000007F, 32'h208);
    tick();
    chk("ill_flag", 64'(illegal), 64'd1);
    chk("ill_fmt", 64'(imm_fmt), 64'd7);
    chk("ill_imm", 64'(imm), 64'h0);
    chk("ill_op_b", 64'(op_b), 64'h55AA);

    in_valid = 1'b0;
    tick();
    chk("idle_valid", 64'(out_valid), 64'd0);

    // Backpressure: A,B accepted, C held off until the skid drains
    drive(addi(12'd1), 32'h0);
    tick();
    chk("bp_A_out", 64'(imm), 64'd1);
    out_ready = 1'b0;
    drive(addi(12'd2), 32'h0);
    tick();
    chk("bp_in_ready_drop", 64'(in_ready), 64'd0);
    chk("bp_A_hold", 64'(imm), 64'd1);
    drive(addi(12'd3), 32'h0);
    tick();
    chk("bp_still_full", 64'(in_ready), 64'd0);
    chk("bp_A_stable", 64'(imm), 64'd1);
    chk("bp_A_valid", 64'(out_valid), 64'd1);
    out_ready = 1'b1;
    tick();
    chk("bp_B_out", 64'(imm), 64'd2);
    chk("bp_in_ready_back", 64'(in_ready), 64'd1);
    tick();
    chk("bp_C_out", 64'(imm), 64'd3);
    drive(addi(12'd4), 32'h0);
    tick();
    chk("bp_D_out", 64'(imm), 64'd4);
    in_valid = 1'b0;
    tick();
    chk("bp_drained", 64'(out_valid), 64'd0);

    // Continuous streaming: one transfer per cycle
    for (int k = 5; k < 10; k++) begin
      drive(addi(12'(k)), 32'h0);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_out", 64'(imm), 64'(k));
    end
    in_valid = 1'b0;
    tick();

    // Flush with both entries full and a valid input
    out_ready = 1'b0;
    drive(addi(12'h10), 32'h0);
    tick();
    drive(addi(12'h11), 32'h0);
    tick();
    chk("fl_full", 64'(in_ready), 64'd0);
    flush = 1'b1;
    drive(addi(12'h12), 32'h0);
    tick();
    chk("fl_out_valid", 64'(out_valid), 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick();
    chk("fl_no_ghost", 64'(out_valid), 64'd0);

    // Flush while the stage can accept: the input is still dropped
    drive(addi(12'h13), 32'h0);
    tick();
    flush = 1'b1;
    drive(addi(12'h14), 32'h0);
    tick();
    chk("fl2_out_valid", 64'(out_valid), 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    chk("fl2_no_ghost", 64'(out_valid), 64'd0);

    // Asynchronous reset with both entries valid
    out_ready = 1'b0;
    drive(addi(12'h20), 32'h0);
    tick();
    drive(addi(12'h21), 32'h0);
    tick();
    in_valid = 1'b0;
    chk("rr_full", 64'(in_ready), 64'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rr_async_valid", 64'(out_valid), 64'd0);
    chk("rr_async_in_ready", 64'(in_ready), 64'd1);
    chk("rr_async_imm", 64'(imm), 64'd0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(addi(12'h22), 32'h0);
    tick();
    chk("rr_first_valid", 64'(out_valid), 64'd1);
    chk("rr_first_imm", 64'(imm), 64'h22);
    in_valid = 1'b0;
    tick();
    chk("rr_drained", 64'(out_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_gen_stage.md
Name: operand_gen_stage

Overview:
- Next-generation operand-B/immediate generator for the RV decode-to-execute boundary.
- Decodes every RV32I immediate format (I, S, B, U, J) from the opcode, sign-extends to XLEN, and selects ALU operands A and B.
- Registers the results in a 2-entry valid/ready skid buffer so the decode and execute stages stall independently.
- Supports pipeline flush for taken branches and jumps.

Parameters:
- XLEN, 32, datapath width; legal values are 32 and 64; immediates sign-extend to XLEN.
- SKID_EN, 1, 1 gives a 2-entry skid buffer (full throughput); 0 gives a single register (in_ready = !out_valid || out_ready).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  drops all buffered entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- instruction  in  32  raw instruction word
- pc  in  XLEN  instruction address
- rs1_data  in  XLEN  register file read port 1
- rs2_data  in  XLEN  register file read port 2
- out_valid  out  1  output entry valid
- out_ready  in  1  downstream accepts this cycle
- op_a  out  XLEN  ALU operand A
- op_b  out  XLEN  ALU operand B
- imm  out  XLEN  decoded immediate
- store_data  out  XLEN  rs2 value passed through for stores
- imm_fmt  out  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal
- illegal  out  1  unknown opcode

Behaviour:
- Reset (asynchronous, rst_n=0): both entries invalid, out_valid=0, in_ready=1, all data outputs 0. Mid-stream reset discards buffered entries immediately.
- Opcode [6:0] to format mapping:
  - 0000011, 0010011, 1100111 → I
  - 0100011 → S
  - 1100011 → B
  - 0110111, 0010111 → U
  - 1101111 → J
  - 0110011 → R
  - anything else → illegal (imm_fmt=7, illegal=1, imm=0, op_b=rs2_data)
- Immediate construction:
  - I: sext(instr[31:20])
  - S: sext({instr[31:25], instr[11:7]})
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0})
  - U: sext({instr[31:12], 12'b0})
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0})
  - R: 0
- Sign extension replicates instr[31] up to XLEN-1. Shift-immediates keep the raw I immediate; the ALU uses the low bits.
- op_a selection: pc for AUIPC and JAL; 0 for LUI; rs1_data otherwise.
- op_b selection: imm for I, S, U, J; rs2_data for R and B (branch compares use rs2; imm goes out separately for the target adder).
- store_data is always rs2_data.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Latency is 1 cycle: an entry accepted in cycle N appears at the outputs in cycle N+1.
  - Outputs hold stable while out_valid && !out_ready.
- Skid buffer (SKID_EN=1):
  - in_ready is registered as !skid_valid.
  - An input accepted while main is full and not draining goes to skid.
  - When main drains, skid moves to main on the next edge.
  - Sustains one transfer per cycle with no combinational path from out_ready to in_ready.
- Simultaneous input and output transfer with skid empty: main is replaced by the new entry and out_valid stays 1.
- flush:
  - On the next edge both entries are invalid and out_valid=0.
  - An input presented in the flush cycle is dropped.
  - Flush has priority over all transfers.
  - in_ready=1 in the cycle after a flush.
- Ordering is strictly FIFO; no entry is duplicated or lost except by flush or reset.

Decomposition:
- Shared package rv_pkg holds:
  - opcode localparams (OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP)
  - the imm_fmt encoding constants (FMT_R … FMT_ILLEGAL)
- Sub-module imm_decode is purely combinational: instruction → imm, imm_fmt, illegal, parametrised by XLEN.
- The top level holds the operand muxes and the skid-buffer control.

Test Plan:
- Immediate decode, one instruction each with out_ready=1:
  - 0xFFF00093 (addi x1,x0,-1) → imm=op_b=0xFFFFFFFF, imm_fmt=1, 1 cycle after accept.
  - 0x0020A423 (sw x2,8(x1)) → imm=0x00000008, imm_fmt=2, store_data=rs2_data.
  - 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC, imm_fmt=3, op_b=rs2_data.
- Operand A selection:
  - 0x123452B7 (lui x5,0x12345) → imm=0x12345000, op_a=0.
  - AUIPC with pc=0x100 → op_a=0x100.
  - Opcode 0x7F → illegal=1, imm_fmt=7.
- XLEN=64: 0xFFF00093 → imm=0xFFFFFFFFFFFFFFFF.
- Backpressure:
  - Stream 4 entries with out_ready=0 from cycle 2 → in_ready drops after 2 accepts.
  - Release out_ready → outputs in order A, B, C, D with no loss or duplication.
  - Continuous valid/ready → 1 transfer per cycle.
- Flush with both entries full and in_valid=1 → next cycle out_valid=0 and in_ready=1; the flushed input never appears.
- Assert rst_n=0 mid-stream with both entries valid → out_valid falls immediately (asynchronously). After deassert, the first new entry passes with 1-cycle latency.
